wbuf_drain_ctrl: RTL and testbench

Controller for the 4-entry cache write-back buffer. It accepts evictions from the cache with a valid/ready handshake and supplies the buffer's write index. It drains entries to memory in FIFO order over a req/ack handshake. It also gives the cache an address-match hit so a miss to a line still in the buffer can be stalled.

---
 rtl/wbuf_drain_ctrl.sv | 161 ++++++++++++++++
 tb/tb_wbuf_drain_ctrl.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbuf_drain_ctrl.sv
// Write-back buffer controller: address tag store, FIFO pointers and a req/ack drain engine.
// Line data lives in the external buffer; only address tags are kept here.
module wbuf_drain_ctrl #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned PTR_W        = 2,
    parameter int unsigned ADDR_W       = 27,
    parameter int unsigned DATA_W       = 256,
    parameter int unsigned DRAIN_THRESH = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   evict_valid,
    input  logic [ADDR_W-1:0]      evict_addr,
    output logic                   evict_ready,
    output logic                   buf_write_en,
    output logic [PTR_W-1:0]       buf_wr_ptr,
    output logic [PTR_W-1:0]       buf_rd_ptr,
    input  logic [DATA_W+ADDR_W:0] buf_rd_data,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_data,
    input  logic                   mem_ack,
    input  logic [ADDR_W-1:0]      lookup_addr,
    output logic                   lookup_hit,
    input  logic                   flush,
    output logic                   flush_done,
    output logic [PTR_W:0]         count,
    output logic                   full,
    output logic                   empty
);

    typedef enum logic [1:0] {StIdle, StReq, StRetire} state_e;

    localparam logic [PTR_W:0] DepthCnt  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] ThreshCnt = (PTR_W + 1)'(DRAIN_THRESH);

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [ADDR_W-1:0]   tag_q [DEPTH];
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_data_q, mem_data_d;
    logic                flush_done_q, flush_done_d;
    logic                flush_seen_q, flush_seen_d;
    logic                push, retire;
    logic                rd_valid_unused;

    // The buffer's own valid bit is redundant with the controller's occupancy count.
    assign rd_valid_unused = buf_rd_data[0];

    assign full         = (count_q == DepthCnt);
    assign empty        = (count_q == '0);
    assign evict_ready  = !full;
    assign push         = evict_valid && !full;
    assign retire       = (state_q == StRetire);
    assign buf_write_en = push;
    assign buf_wr_ptr   = wr_ptr_q;
    assign buf_rd_ptr   = rd_ptr_q;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign mem_data     = mem_data_q;
    assign flush_done   = flush_done_q;
    assign count        = count_q;

    always_comb begin
        lookup_hit = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[i] && (tag_q[i] == lookup_addr)) begin
                lookup_hit = 1'b1;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        count_d  = count_q;
        if (retire) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        case ({push, retire})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
        // One pulse per flush assertion; re-armed only when flush drops.
        flush_done_d = flush && (count_d == '0) && !flush_seen_q;
        flush_seen_d = flush && (flush_seen_q || flush_done_d);
    end

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        unique case (state_q)
            StIdle: begin
                if ((count_q != '0) && ((count_q >= ThreshCnt) || flush)) begin
                    state_d    = StReq;
                    mem_req_d  = 1'b1;
                    mem_addr_d = buf_rd_data[ADDR_W:1];
                    mem_data_d = buf_rd_data[DATA_W+ADDR_W:ADDR_W+1];
                end
            end
            StReq: begin
                if (mem_ack) begin
                    state_d   = StRetire;
                    mem_req_d = 1'b0;
                end
            end
            StRetire: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tag_q[i] <= '0;
            end
        end else if (push) begin
            tag_q[wr_ptr_q] <= evict_addr;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            valid_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            flush_done_q <= 1'b0;
            flush_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            flush_done_q <= flush_done_d;
            flush_seen_q <= flush_seen_d;
        end
    end

endmodule

// File: tb/tb_wbuf_drain_ctrl.sv
// Bench for wbuf_drain_ctrl: instance 0 drains at occupancy 1, instance 1 at occupancy 3.
// Evicted lines go into a scoreboard queue and are compared when the controller requests them.
module tb_wbuf_drain_ctrl;

    localparam int AW = 27;
    localparam int DW = 256;
    localparam int BW = DW + AW + 1;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          evict_valid  [2];
    logic [AW-1:0] evict_addr   [2];
    logic [DW-1:0] evict_data   [2];
    logic          evict_ready  [2];
    logic          buf_write_en [2];
    logic [1:0]    buf_wr_ptr   [2];
    logic [1:0]    buf_rd_ptr   [2];
    logic [BW-1:0] buf_rd_data  [2];
    logic          mem_req      [2];
    logic [AW-1:0] mem_addr     [2];
    logic [DW-1:0] mem_data     [2];
    logic          mem_ack      [2];
    logic [AW-1:0] lookup_addr  [2];
    logic          lookup_hit   [2];
    logic          flush        [2];
    logic          flush_done   [2];
    logic [2:0]    count        [2];
    logic          full         [2];
    logic          empty        [2];

    int   total = 0;
    int   bad   = 0;
    int   wp [2];
    int   rp [2];
    ent_t sb0 [$];
    ent_t sb1 [$];

    always #5 clock = ~clock;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic [BW-1:0] bufm [4];

        always @(posedge clock) begin
            if (buf_write_en[k]) bufm[buf_wr_ptr[k]] <= {evict_data[k], evict_addr[k], 1'b1};
        end
        assign buf_rd_data[k] = bufm[buf_rd_ptr[k]];

        wbuf_drain_ctrl #(
            .DEPTH       (4),
            .PTR_W       (2),
            .ADDR_W      (AW),
            .DATA_W      (DW),
            .DRAIN_THRESH((k == 0) ? 1 : 3)
        ) dut (
            .clock       (clock),
            .reset       (reset),
            .evict_valid (evict_valid[k]),
            .evict_addr  (evict_addr[k]),
            .evict_ready (evict_ready[k]),
            .buf_write_en(buf_write_en[k]),
            .buf_wr_ptr  (buf_wr_ptr[k]),
            .buf_rd_ptr  (buf_rd_ptr[k]),
            .buf_rd_data (buf_rd_data[k]),
            .mem_req     (mem_req[k]),
            .mem_addr    (mem_addr[k]),
            .mem_data    (mem_data[k]),
            .mem_ack     (mem_ack[k]),
            .lookup_addr (lookup_addr[k]),
            .lookup_hit  (lookup_hit[k]),
            .flush       (flush[k]),
            .flush_done  (flush_done[k]),
            .count       (count[k]),
            .full        (full[k]),
            .empty       (empty[k])
        );
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want $finish before it");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic clear_model();
        wp = '{0, 0};
        rp = '{0, 0};
        sb0.delete();
        sb1.delete();
    endtask

    task automatic push_one(input int k, input logic [AW-1:0] a, input bit exp_acc);
        ent_t e;
        e.a = a;
        e.d = {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()};
        evict_valid[k] = 1'b1;
        evict_addr[k]  = a;
        evict_data[k]  = e.d;
        #1;
        total++;
        if (buf_write_en[k] !== exp_acc || evict_ready[k] !== exp_acc) begin
            bad++;
            $display("FAIL push_accept k=%0d addr=%h: wr_en=%b ready=%b, want %b",
                     k, a, buf_write_en[k], evict_ready[k], exp_acc);
        end
        if (exp_acc) begin
            total++;
            if (buf_wr_ptr[k] !== 2'(wp[k])) begin
                bad++;
                $display("FAIL push_wr_ptr k=%0d: got %0d, want %0d", k, buf_wr_ptr[k], wp[k]);
            end
            wp[k] = (wp[k] + 1) % 4;
            if (k == 0) sb0.push_back(e);
            else sb1.push_back(e);
        end
        tick();
        evict_valid[k] = 1'b0;
    endtask

    // Waits for a request, checks it against the scoreboard for hold+1 cycles, then acks.
    // Returns in the cycle after the ack edge (controller in its retire cycle).
    task automatic serve(input int k, input int hold);
        ent_t e;
        int   waited = 0;
        while (mem_req[k] !== 1'b1 && waited < 30) begin
            tick();
            waited++;
        end
        total++;
        if (mem_req[k] !== 1'b1) begin
            bad++;
            $display("FAIL serve_timeout k=%0d: mem_req=%b after 30 cycles, want 1", k, mem_req[k]);
            return;
        end
        if ((k == 0 && sb0.size() == 0) || (k == 1 && sb1.size() == 0)) begin
            bad++;
            $display("FAIL serve_unexpected k=%0d: request addr=%h, want no request", k, mem_addr[k]);
            return;
        end
        if (k == 0) e = sb0.pop_front();
        else e = sb1.pop_front();
        total++;
        if (buf_rd_ptr[k] !== 2'(rp[k])) begin
            bad++;
            $display("FAIL serve_rd_ptr k=%0d: got %0d, want %0d", k, buf_rd_ptr[k], rp[k]);
        end
        for (int c = 0; c <= hold; c++) begin
            total++;
            if (mem_req[k] !== 1'b1 || mem_addr[k] !== e.a || mem_data[k] !== e.d) begin
                bad++;
                $display("FAIL serve_req k=%0d cyc=%0d: req=%b addr=%h data=%h, want 1 %h %h",
                         k, c, mem_req[k], mem_addr[k], mem_data[k], e.a, e.d);
            end
            if (c < hold) tick();
        end
        mem_ack[k] = 1'b1;
        tick();
        mem_ack[k] = 1'b0;
        total++;
        if (mem_req[k] !== 1'b0) begin
            bad++;
            $display("FAIL serve_req_drop k=%0d: mem_req=%b, want 0", k, mem_req[k]);
        end
        rp[k] = (rp[k] + 1) % 4;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({mem_req[k], flush_done[k], empty[k], full[k], evict_ready[k], lookup_hit[k],
                 count[k]} !== 9'b0_0_1_0_1_0_000 || mem_addr[k] !== '0 || mem_data[k] !== '0) begin
                bad++;
                $display("FAIL %s k=%0d: req=%b fdone=%b empty=%b full=%b ready=%b hit=%b cnt=%0d addr=%h, want 0 0 1 0 1 0 0 0",
                         tag, k, mem_req[k], flush_done[k], empty[k], full[k], evict_ready[k],
                         lookup_hit[k], count[k], mem_addr[k]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        check_reset_outputs("reset_state");
        reset = 1'b0;
        clear_model();
    endtask

    task automatic test_basic();
        push_one(0, 27'h0000123, 1'b1);
        total++;
        if (count[0] !== 3'd1 || mem_req[0] !== 1'b0) begin
            bad++;
            $display("FAIL basic_count k=0: count=%0d req=%b, want 1 0", count[0], mem_req[0]);
        end
        tick();
        total++;
        if (mem_req[0] !== 1'b1 || mem_addr[0] !== 27'h0000123) begin
            bad++;
            $display("FAIL basic_req_latency: req=%b addr=%h, want 1 0000123", mem_req[0], mem_addr[0]);
        end
        serve(0, 3);
        tick();
        total++;
        if (count[0] !== 3'd0 || empty[0] !== 1'b1) begin
            bad++;
            $display("FAIL basic_retire: count=%0d empty=%b, want 0 1", count[0], empty[0]);
        end
    endtask

    task automatic test_full_back_to_back();
        for (int i = 0; i < 4; i++) push_one(0, 27'h0ABC000 + 27'(i), 1'b1);
        total++;
        if (count[0] !== 3'd4 || full[0] !== 1'b1 || evict_ready[0] !== 1'b0) begin
            bad++;
            $display("FAIL full_flags: count=%0d full=%b ready=%b, want 4 1 0",
                     count[0], full[0], evict_ready[0]);
        end
        push_one(0, 27'h0000005, 1'b0);
        total++;
        if (count[0] !== 3'd4) begin
            bad++;
            $display("FAIL full_refused_count: count=%0d, want 4", count[0]);
        end
        lookup_addr[0] = 27'h0ABC002;
        #1;
        total++;
        if (lookup_hit[0] !== 1'b1) begin
            bad++;
            $display("FAIL full_lookup: hit=%b, want 1", lookup_hit[0]);
        end
        for (int i = 0; i < 4; i++) begin
            serve(0, i);
            tick();
            total++;
            if (mem_req[0] !== 1'b0) begin
                bad++;
                $display("FAIL b2b_idle_gap entry=%0d: mem_req=%b, want 0", i, mem_req[0]);
            end
        end
        total++;
        if (empty[0] !== 1'b1 || count[0] !== 3'd0) begin
            bad++;
            $display("FAIL full_drained: empty=%b count=%0d, want 1 0", empty[0], count[0]);
        end
    endtask

    task automatic test_lookup();
        ent_t e;
        push_one(0, 27'h0000001, 1'b1);
        // A line being written this cycle is not yet visible to lookup.
        lookup_addr[0]  = 27'h0000002;
        e.a             = 27'h0000002;
        e.d             = {8{32'hC0DE_0002}};
        evict_valid[0]  = 1'b1;
        evict_addr[0]   = e.a;
        evict_data[0]   = e.d;
        #1;
        total++;
        if (lookup_hit[0] !== 1'b0 || buf_write_en[0] !== 1'b1) begin
            bad++;
            $display("FAIL lookup_same_cycle: hit=%b wr_en=%b, want 0 1", lookup_hit[0], buf_write_en[0]);
        end
        wp[0] = (wp[0] + 1) % 4;
        sb0.push_back(e);
        tick();
        evict_valid[0] = 1'b0;
        #1;
        total++;
        if (lookup_hit[0] !== 1'b1) begin
            bad++;
            $display("FAIL lookup_hit_2: hit=%b, want 1", lookup_hit[0]);
        end
        lookup_addr[0] = 27'h0000001;
        #1;
        total++;
        if (lookup_hit[0] !== 1'b1) begin
            bad++;
            $display("FAIL lookup_head_req: hit=%b, want 1", lookup_hit[0]);
        end
        serve(0, 2);
        #1;
        total++;
        if (lookup_hit[0] !== 1'b1) begin
            bad++;
            $display("FAIL lookup_head_retire_cycle: hit=%b, want 1", lookup_hit[0]);
        end
        tick();
        #1;
        total++;
        if (lookup_hit[0] !== 1'b0) begin
            bad++;
            $display("FAIL lookup_head_retired: hit=%b, want 0", lookup_hit[0]);
        end
        lookup_addr[0] = 27'h0000002;
        serve(0, 1);
        tick();
        #1;
        total++;
        if (lookup_hit[0] !== 1'b0) begin
            bad++;
            $display("FAIL lookup_all_retired: hit=%b, want 0", lookup_hit[0]);
        end
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_model();
        for (int i = 0; i < 3; i++) push_one(0, 27'h0000100 + 27'(i), 1'b1);
        serve(0, 1);
        // Push lands on the retire edge: occupancy holds, both pointers move.
        push_one(0, 27'h0000103, 1'b1);
        total++;
        if (count[0] !== 3'd3 || buf_wr_ptr[0] !== 2'd0 || buf_rd_ptr[0] !== 2'd1) begin
            bad++;
            $display("FAIL wrap_push_retire: count=%0d wr=%0d rd=%0d, want 3 0 1",
                     count[0], buf_wr_ptr[0], buf_rd_ptr[0]);
        end
        for (int i = 0; i < 3; i++) serve(0, 0);
        tick();
        total++;
        if (count[0] !== 3'd0) begin
            bad++;
            $display("FAIL wrap_drained: count=%0d, want 0", count[0]);
        end
    endtask

    task automatic test_flush();
        push_one(1, 27'h0000010, 1'b1);
        push_one(1, 27'h0000020, 1'b1);
        mem_ack[1] = 1'b1;
        repeat (4) tick();
        mem_ack[1] = 1'b0;
        total++;
        if (mem_req[1] !== 1'b0 || count[1] !== 3'd2) begin
            bad++;
            $display("FAIL flush_below_thresh: req=%b count=%0d, want 0 2", mem_req[1], count[1]);
        end
        flush[1] = 1'b1;
        serve(1, 1);
        total++;
        if (flush_done[1] !== 1'b0) begin
            bad++;
            $display("FAIL flush_done_early: flush_done=%b, want 0", flush_done[1]);
        end
        serve(1, 1);
        tick();
        total++;
        if (count[1] !== 3'd0 || flush_done[1] !== 1'b1) begin
            bad++;
            $display("FAIL flush_done_pulse: count=%0d flush_done=%b, want 0 1", count[1], flush_done[1]);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (flush_done[1] !== 1'b0) begin
                bad++;
                $display("FAIL flush_done_once cyc=%0d: flush_done=%b, want 0", i, flush_done[1]);
            end
        end
        flush[1] = 1'b0;
        tick();
        flush[1] = 1'b1;
        tick();
        total++;
        if (flush_done[1] !== 1'b1) begin
            bad++;
            $display("FAIL flush_empty_rise: flush_done=%b, want 1", flush_done[1]);
        end
        tick();
        total++;
        if (flush_done[1] !== 1'b0) begin
            bad++;
            $display("FAIL flush_empty_once: flush_done=%b, want 0", flush_done[1]);
        end
        flush[1] = 1'b0;
    endtask

    task automatic test_reset_mid_req();
        push_one(0, 27'h0000077, 1'b1);
        push_one(0, 27'h0000088, 1'b1);
        total++;
        if (mem_req[0] !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pre: mem_req=%b, want 1", mem_req[0]);
        end
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid_async");
        tick();
        reset = 1'b0;
        clear_model();
        lookup_addr[0] = 27'h0000077;
        #1;
        total++;
        if (lookup_hit[0] !== 1'b0) begin
            bad++;
            $display("FAIL rst_lookup_77: hit=%b, want 0", lookup_hit[0]);
        end
        lookup_addr[0] = 27'h0000088;
        #1;
        total++;
        if (lookup_hit[0] !== 1'b0) begin
            bad++;
            $display("FAIL rst_lookup_88: hit=%b, want 0", lookup_hit[0]);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            evict_valid[k] = 1'b0;
            evict_addr[k]  = '0;
            evict_data[k]  = '0;
            mem_ack[k]     = 1'b0;
            lookup_addr[k] = '0;
            flush[k]       = 1'b0;
        end
        clear_model();
        test_reset();
        test_basic();
        test_full_back_to_back();
        test_lookup();
        test_wrap();
        test_flush();
        test_reset_mid_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
